fp16_lane_serializer: RTL

Upstream feeder for the fp16 running-max unit. Accepts packed vectors of `LANES` fp16 scores over a valid/ready handshake and emits them one lane per cycle as `update`/value/index pulses. Index is a running element position within the current sequence. `seq_done` flags the cycle in which the downstream max is final for that sequence.

---
 rtl/fp16_pkg.sv | 23 ++
 rtl/fp16_lane_serializer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fp16_pkg.sv
// Purpose : shared fp16 field constants, NaN classifier and serializer FSM state type.
// Latency : n/a (package).
// Backpressure: n/a (package).
package fp16_pkg;

    // fp16 layout: [15] sign, [14:10] exponent, [9:0] fraction
    localparam int FP16_EXP_MSB = 14;
    localparam int FP16_EXP_LSB = 10;
    localparam int FP16_FRAC_W  = 10;
    localparam logic [FP16_EXP_MSB-FP16_EXP_LSB:0] FP16_EXP_MAX = 5'h1F;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // All-ones exponent with a non-zero fraction is NaN; zero fraction is +/-Inf.
    function automatic logic fp16_is_nan(input logic [15:0] v);
        return (v[FP16_EXP_MSB:FP16_EXP_LSB] == FP16_EXP_MAX) &&
               (v[FP16_FRAC_W-1:0] != '0);
    endfunction

endpackage

// File: rtl/fp16_lane_serializer.sv
// Purpose : serialize LANES-wide fp16 words into one registered element per cycle for the running-max unit.
// Latency : handshake at cycle t -> lane 0 on outputs at t+1, lane k at t+1+k; seq_done one cycle after the last lane.
// Backpressure: in_ready only in IDLE or while the final lane of a word is on the outputs (zero-bubble chaining).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   seq_start             synchronous abort: drop pending lanes, index := 0, back to IDLE
//   in_valid/in_ready     word handshake; in_data (lane i at [i*16 +: 16]), in_mask, in_last
//   update                one element valid this cycle; out_value / out_index describe it
//   seq_done              one-cycle pulse when the downstream max is final for the sequence
//
// Optional feature: define FP16_NAN_SKIP_EN to suppress update for NaN lanes (index still consumed).
module fp16_lane_serializer
    import fp16_pkg::*;
#(
    parameter int LANES       = 8,
    parameter int INDEX_WIDTH = 16,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        seq_start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic [LANES-1:0]            in_mask,
    input  logic                        in_last,
    output logic                        update,
    output logic [DATA_WIDTH-1:0]       out_value,
    output logic [INDEX_WIDTH-1:0]      out_index,
    output logic                        seq_done
);

    localparam int LANE_W = $clog2(LANES);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

    ser_state_t                  state_q, state_d;
    logic [LANES*DATA_WIDTH-1:0] data_q, data_d;
    logic [LANES-1:0]            mask_q, mask_d;
    logic                        last_q, last_d;
    // lane_cnt_q is the lane currently presented on the output registers
    logic [LANE_W-1:0]           lane_cnt_q, lane_cnt_d;
    // idx_cnt_q is the index the next emitted lane will carry
    logic [INDEX_WIDTH-1:0]      idx_cnt_q, idx_cnt_d;
    logic                        update_q, update_d;
    logic [DATA_WIDTH-1:0]       out_value_q, out_value_d;
    logic [INDEX_WIDTH-1:0]      out_index_q, out_index_d;
    logic                        seq_done_q, seq_done_d;

    logic                        at_last;
    logic                        seq_end;
    logic                        hs;
    logic [INDEX_WIDTH-1:0]      idx_base;

    logic                        emit_en;
    logic [LANE_W-1:0]           emit_lane;
    logic [LANES*DATA_WIDTH-1:0] emit_word;
    logic [LANES-1:0]            emit_mask;
    logic [DATA_WIDTH-1:0]       elem;
    logic                        nan_drop;

    assign at_last  = (state_q == SHIFT) && (lane_cnt_q == LANE_LAST);
    assign in_ready = !seq_start && ((state_q == IDLE) || at_last);
    assign hs       = in_valid && in_ready;

    // Final lane of a last word is on the outputs: whatever is emitted next
    // belongs to a fresh sequence and must start at index 0.
    assign seq_end  = at_last && last_q;
    assign idx_base = seq_end ? '0 : idx_cnt_q;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        mask_d      = mask_q;
        last_d      = last_q;
        lane_cnt_d  = lane_cnt_q;
        idx_cnt_d   = idx_cnt_q;
        update_d    = 1'b0;
        out_value_d = out_value_q;
        out_index_d = out_index_q;
        seq_done_d  = 1'b0;
        emit_en     = 1'b0;
        emit_lane   = '0;
        emit_word   = data_q;
        emit_mask   = mask_q;
        elem        = '0;
        nan_drop    = 1'b0;

        if (seq_start) begin
            state_d   = IDLE;
            idx_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        state_d    = SHIFT;
                        data_d     = in_data;
                        mask_d     = in_mask;
                        last_d     = in_last;
                        lane_cnt_d = '0;
                        emit_en    = 1'b1;
                        emit_word  = in_data;
                        emit_mask  = in_mask;
                    end
                end
                SHIFT: begin
                    seq_done_d = seq_end;
                    if (!at_last) begin
                        lane_cnt_d = lane_cnt_q + 1'b1;
                        emit_en    = 1'b1;
                        emit_lane  = lane_cnt_q + 1'b1;
                    end else if (hs) begin
                        data_d     = in_data;
                        mask_d     = in_mask;
                        last_d     = in_last;
                        lane_cnt_d = '0;
                        emit_en    = 1'b1;
                        emit_word  = in_data;
                        emit_mask  = in_mask;
                    end else begin
                        state_d   = IDLE;
                        idx_cnt_d = idx_base;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (emit_en) begin
            elem = emit_word[int'(emit_lane)*DATA_WIDTH +: DATA_WIDTH];
`ifdef FP16_NAN_SKIP_EN
            nan_drop = fp16_is_nan(elem);
`else
            nan_drop = 1'b0;
`endif
            // Masked/NaN lanes still show their contents and consume an index.
            out_value_d = elem;
            out_index_d = idx_base;
            idx_cnt_d   = idx_base + 1'b1;
            update_d    = emit_mask[emit_lane] && !nan_drop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            mask_q      <= '0;
            last_q      <= 1'b0;
            lane_cnt_q  <= '0;
            idx_cnt_q   <= '0;
            update_q    <= 1'b0;
            out_value_q <= '0;
            out_index_q <= '0;
            seq_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            last_q      <= last_d;
            lane_cnt_q  <= lane_cnt_d;
            idx_cnt_q   <= idx_cnt_d;
            update_q    <= update_d;
            out_value_q <= out_value_d;
            out_index_q <= out_index_d;
            seq_done_q  <= seq_done_d;
        end
    end

    assign update    = update_q;
    assign out_value = out_value_q;
    assign out_index = out_index_q;
    assign seq_done  = seq_done_q;

endmodule
